// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads 1- or 2-byte instructions from a 1-cycle byte memory
// and presents them on a valid/ready port. Optional halt detection under IFU_HALT_DETECT_EN.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int                ADDR_W   = 13,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  resetN,
    output logic                  memRead,
    output logic [ADDR_W-1:0]     addressMem,
    input  logic [DATA_W-1:0]     memOut,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     jumpAddr,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [2*DATA_W-1:0]   instr,
    output logic                  instrLen,
    output logic [ADDR_W-1:0]     instrPc,
    output logic                  halted,
    output logic [2:0]            fetchState
);

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_L0   = 3'd1,
        S_F1   = 3'd2,
        S_L1   = 3'd3,
        S_HOLD = 3'd4,
        S_PARK = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   pc_plus1;
    logic [ADDR_W-1:0]   pc_seq;
    logic                accept;
    logic                two_byte;

    // Output handshake: instr/instrLen/instrPc are held constant while instrValid is high
    // and are consumed on a cycle where instrValid && instrReady; only jump/reset drop valid.
    assign instrValid = (state_q == S_HOLD);
    assign accept     = instrValid && instrReady;
    assign fetchState = state_q;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign pc_seq   = pc_q + ADDR_W'(1) + ADDR_W'(instrLen);

`ifdef IFU_HALT_DETECT_EN
    logic halt_op;
    logic halted_q;

    // A zero opcode byte is a 1-byte halt rather than the 2-byte op it would otherwise be.
    assign two_byte = !memOut[DATA_W-1] && (memOut != '0);
    assign halt_op  = (instr[2*DATA_W-1 -: DATA_W] == '0) && !instrLen;
    assign halted   = halted_q;
`else
    assign two_byte = !memOut[DATA_W-1];
    assign halted   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_F0:   state_d = S_L0;
            S_L0:   state_d = two_byte ? S_F1 : S_HOLD;
            S_F1:   state_d = S_L1;
            S_L1:   state_d = S_HOLD;
            S_HOLD: begin
                if (accept) begin
                    state_d = S_F0;
`ifdef IFU_HALT_DETECT_EN
                    if (halt_op) state_d = S_PARK;
`endif
                end
            end
            S_PARK: state_d = S_PARK;
            default: state_d = S_F0;
        endcase
        if (jump) state_d = S_F0;
    end

    // Read strobe is gated by resetN so memory sees no request while reset is held.
    always_comb begin
        memRead    = 1'b0;
        addressMem = addr_q;
        case (state_q)
            S_F0: begin
                memRead    = resetN;
                addressMem = pc_q;
            end
            S_F1: begin
                memRead    = resetN;
                addressMem = pc_plus1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_F0;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addressMem;
            if (jump) begin
                pc_q <= jumpAddr;
            end else if (accept) begin
                pc_q <= pc_seq;
            end
        end
    end

    // Byte capture; a jump discards whatever byte is returning this cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            instr    <= '0;
            instrLen <= 1'b0;
            instrPc  <= RESET_PC;
        end else if (!jump) begin
            if (state_q == S_L0) begin
                instr    <= {memOut, {DATA_W{1'b0}}};
                instrLen <= two_byte;
                instrPc  <= pc_q;
            end else if (state_q == S_L1) begin
                instr[DATA_W-1:0] <= memOut;
            end
        end
    end

`ifdef IFU_HALT_DETECT_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            halted_q <= 1'b0;
        end else if (jump) begin
            halted_q <= 1'b0;
        end else if (accept && halt_op) begin
            halted_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model, timing checks in the driver,
// and a scoreboard monitor comparing every accepted instruction against exp_q.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic              memRead;
  logic [ADDR_W-1:0] addressMem;
  logic [DATA_W-1:0] memOut = '0;
  logic              jump = 1'b0;
  logic [ADDR_W-1:0] jumpAddr = '0;
  logic              instrValid;
  logic              instrReady = 1'b0;
  logic [15:0]       instr;
  logic              instrLen;
  logic [ADDR_W-1:0] instrPc;
  logic              halted;
  logic [2:0]        fetchState;

  logic [7:0]  mem [0:8191];
  logic [29:0] exp_q[$];
  int          tests = 0;
  int          failed = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
    .clock(clock), .resetN(resetN), .memRead(memRead), .addressMem(addressMem),
    .memOut(memOut), .jump(jump), .jumpAddr(jumpAddr), .instrValid(instrValid),
    .instrReady(instrReady), .instr(instr), .instrLen(instrLen), .instrPc(instrPc),
    .halted(halted), .fetchState(fetchState)
  );

  // clock / reset / memory model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memRead) memOut <= mem[addressMem];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clock);
  endtask

  task automatic push_exp(input logic [15:0] i, input logic l, input logic [12:0] pc);
    exp_q.push_back({i, l, pc});
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    jump = 1'b0;
    instrReady = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_memread", memRead, 0);
    check("rst_addr", addressMem, 0);
    check("rst_valid", instrValid, 0);
    check("rst_instr", instr, 0);
    check("rst_len", instrLen, 0);
    check("rst_pc", instrPc, 0);
    check("rst_halted", halted, 0);
    check("rst_state", fetchState, 0);
    resetN = 1'b1;
    #1;
  endtask

  // scoreboard monitor
  always begin
    @(negedge clock);
    #2;
    if (resetN && instrValid && instrReady) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected: got instr %0h len %0d pc %0d with no expectation",
                 instr, instrLen, instrPc);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        if ({instr, instrLen, instrPc} !== e) begin
          failed++;
          $display("FAIL sb_instr: got instr %0h len %0d pc %0d expected instr %0h len %0d pc %0d",
                   instr, instrLen, instrPc, e[29:14], e[13], e[12:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h80;
    mem[0]    = 8'hE8;
    mem[9]    = 8'h43;
    mem[10]   = 8'hE9;
    mem[1000] = 8'd40;
    mem[1001] = 8'h00;
    mem[8191] = 8'h20;
    mem[5]    = 8'h00;
    mem[6]    = 8'h12;

    // A: 1-byte fetch right out of reset
    do_reset();
    check("a_memread", memRead, 1);
    check("a_addr", addressMem, 0);
    push_exp(16'hE800, 1'b0, 13'd0);
    instrReady = 1'b1;
    next();
    check("a_l0_valid", instrValid, 0);
    next();
    check("a_valid", instrValid, 1);
    check("a_instr", instr, 16'hE800);
    check("a_len", instrLen, 0);
    check("a_pc", instrPc, 0);
    next();
    check("a_next_rd", memRead, 1);
    check("a_next_addr", addressMem, 1);
    instrReady = 1'b0;

    // B: 2-byte fetch at pc 9, then C: backpressure on the following 1-byte op at 11
    do_reset();
    jump = 1'b1;
    jumpAddr = 13'd9;
    next();
    jump = 1'b0;
    check("b_rd0", memRead, 1);
    check("b_addr0", addressMem, 9);
    next();
    check("b_l0_rd", memRead, 0);
    next();
    check("b_rd1", memRead, 1);
    check("b_addr1", addressMem, 10);
    next();
    check("b_l1_valid", instrValid, 0);
    next();
    check("b_valid", instrValid, 1);
    check("b_instr", instr, 16'h43E9);
    check("b_len", instrLen, 1);
    push_exp(16'h43E9, 1'b1, 13'd9);
    instrReady = 1'b1;
    next();
    check("b_next_addr", addressMem, 11);
    instrReady = 1'b0;
    repeat (2) next();
    for (int i = 0; i < 5; i++) begin
      check("c_valid", instrValid, 1);
      check("c_instr", instr, 16'h8000);
      check("c_pc", instrPc, 11);
      check("c_no_rd", memRead, 0);
      if (i < 4) next();
    end
    push_exp(16'h8000, 1'b0, 13'd11);
    instrReady = 1'b1;
    next();
    check("c_next_rd", memRead, 1);
    check("c_next_addr", addressMem, 12);
    instrReady = 1'b0;

    // D: jump during L0 of a 2-byte fetch abandons it
    mem[0] = 8'h05;
    do_reset();
    next();
    jump = 1'b1;
    jumpAddr = 13'd1000;
    next();
    jump = 1'b0;
    check("d_rd", memRead, 1);
    check("d_addr", addressMem, 1000);
    for (int i = 0; i < 3; i++) begin
      next();
      check("d_no_valid", instrValid, 0);
    end
    check("d_addr1", addressMem, 1001);
    next();
    check("d_valid", instrValid, 1);
    check("d_instr", instr, 16'h2800);
    push_exp(16'h2800, 1'b1, 13'd1000);
    instrReady = 1'b1;
    next();
    check("d_next_addr", addressMem, 1002);
    instrReady = 1'b0;

    // E: wrap of byte1 address, then F: jump coincident with acceptance
    mem[0] = 8'h11;
    mem[1] = 8'h80;
    do_reset();
    jump = 1'b1;
    jumpAddr = 13'd8191;
    next();
    jump = 1'b0;
    check("e_addr0", addressMem, 8191);
    repeat (2) next();
    check("e_rd1", memRead, 1);
    check("e_addr1", addressMem, 0);
    repeat (2) next();
    check("e_instr", instr, 16'h2011);
    check("e_pc", instrPc, 8191);
    push_exp(16'h2011, 1'b1, 13'd8191);
    instrReady = 1'b1;
    next();
    check("e_next_addr", addressMem, 1);
    instrReady = 1'b0;
    repeat (2) next();
    check("f_valid", instrValid, 1);
    push_exp(16'h8000, 1'b0, 13'd1);
    instrReady = 1'b1;
    jump = 1'b1;
    jumpAddr = 13'd50;
    next();
    jump = 1'b0;
    instrReady = 1'b0;
    check("f_rd", memRead, 1);
    check("f_addr", addressMem, 50);

    // G: zero opcode byte at address 5
    do_reset();
    jump = 1'b1;
    jumpAddr = 13'd5;
    next();
    jump = 1'b0;
    check("g_addr0", addressMem, 5);
`ifdef IFU_HALT_DETECT_EN
    repeat (2) next();
    check("g_valid", instrValid, 1);
    check("g_instr", instr, 16'h0000);
    check("g_len", instrLen, 0);
    check("g_not_halted", halted, 0);
    push_exp(16'h0000, 1'b0, 13'd5);
    instrReady = 1'b1;
    next();
    instrReady = 1'b0;
    check("g_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      check("g_park_rd", memRead, 0);
      check("g_park_valid", instrValid, 0);
      next();
    end
    jump = 1'b1;
    jumpAddr = 13'd0;
    next();
    jump = 1'b0;
    check("g_unhalted", halted, 0);
    check("g_resume_rd", memRead, 1);
    check("g_resume_addr", addressMem, 0);
`else
    repeat (2) next();
    check("g_rd1", memRead, 1);
    check("g_addr1", addressMem, 6);
    repeat (2) next();
    check("g_valid", instrValid, 1);
    check("g_instr", instr, 16'h0012);
    check("g_len", instrLen, 1);
    check("g_halted", halted, 0);
    push_exp(16'h0012, 1'b1, 13'd5);
    instrReady = 1'b1;
    next();
    instrReady = 1'b0;
    check("g_next_addr", addressMem, 7);
    check("g_halted_after", halted, 0);
`endif

    // final report
    repeat (3) next();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
